ddr2_wr_arbiter: RTL and testbench
==================================

DDR2_WR_ARBITER -- requirements
Module: ddr2_wr_arbiter

Interface
REQ-001 SHALL have parameter BEATS, default 2: wdf beats per transaction, legal range 1..4.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have ports m0_req / m1_req, input, 1 each: master has a write transaction pending (m0 = frame filler, m1 = line engine).
REQ-005 SHALL have ports mN_af_addr_din, input, 31; mN_af_wr_en, input, 1; mN_wdf_din, input, 128; mN_wdf_mask_din, input, 16; mN_wdf_wr_en, input, 1 (N = 0, 1).
REQ-006 SHALL have ports mN_af_full / mN_wdf_full, output, 1 each: per-master back-pressure.
REQ-007 SHALL have ports mN_gnt, output, 1: master N owns the DDR2 write port.
REQ-008 SHALL have ports af_full, wdf_full, input, 1: DDR2 FIFO back-pressure.
REQ-009 SHALL have ports af_addr_din, output, 31; af_wr_en, output, 1; wdf_din, output, 128; wdf_mask_din, output, 16; wdf_wr_en, output, 1: DDR2 FIFO write side.

Function
REQ-010 SHALL implement FSM IDLE -> GRANT -> IDLE; transaction = one af write plus BEATS wdf writes, never interleaved between masters.
REQ-011 IDLE: SHALL sample m0_req/m1_req; any request -> GRANT next cycle with mN_gnt registered high (1-cycle req-to-grant latency).
REQ-012 Both requesting in IDLE: SHALL grant the master not granted last (round-robin, see REQ-024); after reset m0 wins.
REQ-013 GRANT: SHALL pass granted master's addr/din/mask straight through; af_wr_en = mN_af_wr_en & !af_full; wdf_wr_en = mN_wdf_wr_en & !wdf_full.
REQ-014 Granted master SHALL see mN_af_full = af_full, mN_wdf_full = wdf_full; non-granted master SHALL see both full flags = 1.
REQ-015 In IDLE both masters SHALL see both full flags = 1; af_wr_en = wdf_wr_en = 0, wdf_mask_din = 16'hFFFF, af_addr_din = 0, wdf_din = 0.
REQ-016 Beat counter (2 bits) SHALL increment on each accepted wdf write (wdf_wr_en high); counter clears on entering GRANT.
REQ-017 On acceptance of beat BEATS (counter == BEATS-1 and wdf_wr_en) SHALL return to IDLE next cycle, clear mN_gnt, record last-granted master.
REQ-018 Second af write in one transaction (af_wr_en with af-accepted flag set) SHALL be blocked (af_wr_en forced 0) and held off until next grant.
REQ-019 Granted master dropping req mid-transaction SHALL NOT release grant; only beat completion ends GRANT.
REQ-020 af_full/wdf_full asserted mid-transaction: SHALL hold GRANT and counter, no beat counted, until acceptance.
REQ-021 A master requesting in the cycle GRANT completes SHALL be arbitrated in IDLE next cycle (one IDLE bubble between transactions, always).

Reset
REQ-022 rst_n low SHALL immediately force IDLE, mN_gnt = 0, counter = 0, last-granted = m1 (so m0 wins first), af_wr_en = wdf_wr_en = 0, all mN full flags = 1.
REQ-023 Reset mid-transaction SHALL abandon partial transaction; no beat completion after release; first edge with rst_n high evaluates IDLE.

Configuration
REQ-024 Macro DDR2_WR_ARB_RR_EN defined: round-robin per REQ-012; undefined: fixed priority, m0 always wins simultaneous requests, last-granted register omitted.

Verification
REQ-025 Only m0_req=1, BEATS=2, no full -> m0_gnt high cycle 1, af_wr_en+wdf_wr_en cycle 1, wdf_wr_en cycle 2, m0_gnt low cycle 3.
REQ-026 m0_req=m1_req=1 held, RR enabled -> grant sequence m0,m1,m0,m1; RR disabled -> m0,m0,m0; m1_af_full/m1_wdf_full stay 1 throughout with RR disabled.
REQ-027 m1 granted, wdf_full=1 for 5 cycles after beat 1 -> wdf_wr_en 0, counter holds 1, grant held; completes on first cycle wdf_full=0.
REQ-028 m0 asserts mN_af_wr_en on both beats -> only one af_wr_en pulse; wdf_mask_din/wdf_din equal m0 inputs during GRANT, 16'hFFFF/0 in IDLE.
REQ-029 rst_n low in GRANT after beat 1 -> same cycle gnt=0, wr_ens=0; after release with m1_req=1, m0_req=1 -> m0 granted first.

Source files
------------

// File: rtl/ddr2_wr_arbiter_if.sv
// Bus bundle between the two write masters, the arbiter and the DDR2 write FIFOs.
// slave: arbiter view. master: the environment (masters plus DDR2 FIFOs).
interface ddr2_wr_arbiter_if;
    logic         m0_req;
    logic [30:0]  m0_af_addr_din;
    logic         m0_af_wr_en;
    logic [127:0] m0_wdf_din;
    logic [15:0]  m0_wdf_mask_din;
    logic         m0_wdf_wr_en;
    logic         m0_af_full;
    logic         m0_wdf_full;
    logic         m0_gnt;

    logic         m1_req;
    logic [30:0]  m1_af_addr_din;
    logic         m1_af_wr_en;
    logic [127:0] m1_wdf_din;
    logic [15:0]  m1_wdf_mask_din;
    logic         m1_wdf_wr_en;
    logic         m1_af_full;
    logic         m1_wdf_full;
    logic         m1_gnt;

    logic         af_full;
    logic         wdf_full;
    logic [30:0]  af_addr_din;
    logic         af_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;
    logic         wdf_wr_en;

    modport slave (
        input  m0_req, m0_af_addr_din, m0_af_wr_en, m0_wdf_din, m0_wdf_mask_din, m0_wdf_wr_en,
        output m0_af_full, m0_wdf_full, m0_gnt,
        input  m1_req, m1_af_addr_din, m1_af_wr_en, m1_wdf_din, m1_wdf_mask_din, m1_wdf_wr_en,
        output m1_af_full, m1_wdf_full, m1_gnt,
        input  af_full, wdf_full,
        output af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en
    );

    modport master (
        output m0_req, m0_af_addr_din, m0_af_wr_en, m0_wdf_din, m0_wdf_mask_din, m0_wdf_wr_en,
        input  m0_af_full, m0_wdf_full, m0_gnt,
        output m1_req, m1_af_addr_din, m1_af_wr_en, m1_wdf_din, m1_wdf_mask_din, m1_wdf_wr_en,
        input  m1_af_full, m1_wdf_full, m1_gnt,
        output af_full, wdf_full,
        input  af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en
    );
endinterface

// File: rtl/ddr2_wr_arbiter.sv
// Two-master arbiter for the DDR2 write port: one af write plus BEATS wdf writes per grant.
// Define DDR2_WR_ARB_RR_EN for round-robin on simultaneous requests; otherwise m0 has fixed priority.
module ddr2_wr_arbiter #(
    parameter int unsigned BEATS = 2
) (
    input logic              clk,
    input logic              rst_n,
    ddr2_wr_arbiter_if.slave bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    state_t       state, state_nxt;
    logic         sel, sel_nxt;
    logic [1:0]   beat_cnt;
    logic         af_done;
    logic         beat_last;

    logic         g_af_wr_en;
    logic         g_wdf_wr_en;
    logic [30:0]  g_addr;
    logic [127:0] g_din;
    logic [15:0]  g_mask;

    logic         af_acc;
    logic         wdf_acc;
    logic [30:0]  addr_out;
    logic [127:0] din_out;
    logic [15:0]  mask_out;
    logic         m0_af_full_o, m0_wdf_full_o, m1_af_full_o, m1_wdf_full_o;

`ifdef DDR2_WR_ARB_RR_EN
    logic last_gnt;
`endif

    always_comb begin
        g_af_wr_en  = sel ? bus.m1_af_wr_en     : bus.m0_af_wr_en;
        g_wdf_wr_en = sel ? bus.m1_wdf_wr_en    : bus.m0_wdf_wr_en;
        g_addr      = sel ? bus.m1_af_addr_din  : bus.m0_af_addr_din;
        g_din       = sel ? bus.m1_wdf_din      : bus.m0_wdf_din;
        g_mask      = sel ? bus.m1_wdf_mask_din : bus.m0_wdf_mask_din;
    end

    always_comb begin
        af_acc        = 1'b0;
        wdf_acc       = 1'b0;
        addr_out      = '0;
        din_out       = '0;
        mask_out      = '1;
        m0_af_full_o  = 1'b1;
        m0_wdf_full_o = 1'b1;
        m1_af_full_o  = 1'b1;
        m1_wdf_full_o = 1'b1;
        if (state == GRANT) begin
            addr_out = g_addr;
            din_out  = g_din;
            mask_out = g_mask;
            // A second address write in the same transaction is swallowed here.
            af_acc   = g_af_wr_en & ~bus.af_full & ~af_done;
            wdf_acc  = g_wdf_wr_en & ~bus.wdf_full;
            if (sel) begin
                m1_af_full_o  = bus.af_full;
                m1_wdf_full_o = bus.wdf_full;
            end else begin
                m0_af_full_o  = bus.af_full;
                m0_wdf_full_o = bus.wdf_full;
            end
        end
    end

    assign beat_last = wdf_acc & (beat_cnt == LAST_BEAT);

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        case (state)
            IDLE: begin
                if (bus.m0_req | bus.m1_req) begin
                    state_nxt = GRANT;
`ifdef DDR2_WR_ARB_RR_EN
                    sel_nxt   = bus.m1_req & (~bus.m0_req | ~last_gnt);
`else
                    sel_nxt   = ~bus.m0_req;
`endif
                end
            end
            GRANT: begin
                if (beat_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel      <= 1'b0;
            beat_cnt <= '0;
            af_done  <= 1'b0;
        end else begin
            sel <= sel_nxt;
            if (state == IDLE) begin
                beat_cnt <= '0;
                af_done  <= 1'b0;
            end else begin
                if (wdf_acc)
                    beat_cnt <= beat_cnt + 2'd1;
                if (af_acc)
                    af_done <= 1'b1;
            end
        end
    end

`ifdef DDR2_WR_ARB_RR_EN
    // Reset to m1 so that m0 wins the first contested arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_gnt <= 1'b1;
        else if (state == GRANT && beat_last)
            last_gnt <= sel;
    end
`endif

    assign bus.m0_gnt       = (state == GRANT) & ~sel;
    assign bus.m1_gnt       = (state == GRANT) & sel;
    assign bus.m0_af_full   = m0_af_full_o;
    assign bus.m0_wdf_full  = m0_wdf_full_o;
    assign bus.m1_af_full   = m1_af_full_o;
    assign bus.m1_wdf_full  = m1_wdf_full_o;
    assign bus.af_addr_din  = addr_out;
    assign bus.af_wr_en     = af_acc;
    assign bus.wdf_din      = din_out;
    assign bus.wdf_mask_din = mask_out;
    assign bus.wdf_wr_en    = wdf_acc;

endmodule

// File: tb/tb_ddr2_wr_arbiter.sv
// Bench for ddr2_wr_arbiter: transaction-level ownership model checked every cycle,
// plus directed scenarios with literal expectations. Honours DDR2_WR_ARB_RR_EN.
module tb_ddr2_wr_arbiter;

    localparam int unsigned BEATS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ddr2_wr_arbiter_if bus();

    ddr2_wr_arbiter #(.BEATS(BEATS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Model: who owns the port (-1 = nobody), beats delivered, whether the address went out.
    int owner = -1;
    int beats_done = 0;
    bit af_used = 1'b0;
    int last_owner = 1;

    typedef struct packed {
        logic         g0, g1, f0a, f0w, f1a, f1w, afen, wdfen;
        logic [30:0]  addr;
        logic [127:0] din;
        logic [15:0]  mask;
    } exp_t;

    function automatic exp_t expect_now();
        exp_t e;
        e = '0;
        e.f0a = 1'b1; e.f0w = 1'b1; e.f1a = 1'b1; e.f1w = 1'b1;
        e.mask = 16'hFFFF;
        if (owner == 0) begin
            e.g0    = 1'b1;
            e.addr  = bus.m0_af_addr_din;
            e.din   = bus.m0_wdf_din;
            e.mask  = bus.m0_wdf_mask_din;
            e.afen  = bus.m0_af_wr_en && !bus.af_full && !af_used;
            e.wdfen = bus.m0_wdf_wr_en && !bus.wdf_full;
            e.f0a   = bus.af_full;
            e.f0w   = bus.wdf_full;
        end else if (owner == 1) begin
            e.g1    = 1'b1;
            e.addr  = bus.m1_af_addr_din;
            e.din   = bus.m1_wdf_din;
            e.mask  = bus.m1_wdf_mask_din;
            e.afen  = bus.m1_af_wr_en && !bus.af_full && !af_used;
            e.wdfen = bus.m1_wdf_wr_en && !bus.wdf_full;
            e.f1a   = bus.af_full;
            e.f1w   = bus.wdf_full;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            owner      <= -1;
            beats_done <= 0;
            af_used    <= 1'b0;
            last_owner <= 1;
        end else if (owner < 0) begin
            if (bus.m0_req || bus.m1_req) begin
`ifdef DDR2_WR_ARB_RR_EN
                if (bus.m0_req && bus.m1_req) owner <= (last_owner == 0) ? 1 : 0;
                else owner <= bus.m0_req ? 0 : 1;
`else
                owner <= bus.m0_req ? 0 : 1;
`endif
                beats_done <= 0;
                af_used    <= 1'b0;
            end
        end else begin
            e = expect_now();
            if (e.afen) af_used <= 1'b1;
            if (e.wdfen) begin
                if (beats_done + 1 == int'(BEATS)) begin
                    last_owner <= owner;
                    owner      <= -1;
                end
                beats_done <= beats_done + 1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = expect_now();
        chk("m0_gnt", bus.m0_gnt, e.g0);
        chk("m1_gnt", bus.m1_gnt, e.g1);
        chk("m0_af_full", bus.m0_af_full, e.f0a);
        chk("m0_wdf_full", bus.m0_wdf_full, e.f0w);
        chk("m1_af_full", bus.m1_af_full, e.f1a);
        chk("m1_wdf_full", bus.m1_wdf_full, e.f1w);
        chk("af_wr_en", bus.af_wr_en, e.afen);
        chk("wdf_wr_en", bus.wdf_wr_en, e.wdfen);
        chk("af_addr_din", bus.af_addr_din, e.addr);
        chk("wdf_din", bus.wdf_din, e.din);
        chk("wdf_mask_din", bus.wdf_mask_din, e.mask);
    end

    // Grant history and m1 flag observation.
    int gq[$];
    logic p0 = 1'b0, p1 = 1'b0;
    bit m1_flag_low = 1'b0;
    always @(negedge clk) begin
        if (bus.m0_gnt && !p0) gq.push_back(0);
        if (bus.m1_gnt && !p1) gq.push_back(1);
        p0 = bus.m0_gnt;
        p1 = bus.m1_gnt;
        if (!bus.m1_af_full || !bus.m1_wdf_full) m1_flag_low = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m0_req = 0; bus.m0_af_wr_en = 0; bus.m0_wdf_wr_en = 0;
        bus.m1_req = 0; bus.m1_af_wr_en = 0; bus.m1_wdf_wr_en = 0;
        bus.af_full = 0; bus.wdf_full = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    int exp_seq[4];

    initial begin
        clear_inputs();
        bus.m0_af_addr_din = 31'h1234_5678; bus.m0_wdf_din = 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF;
        bus.m0_wdf_mask_din = 16'h00F0;
        bus.m1_af_addr_din = 31'h0BAD_CAFE; bus.m1_wdf_din = 128'h5151_5252_5353_5454_5555_5656_5757_5858;
        bus.m1_wdf_mask_din = 16'h0F0F;

        // Reset state
        repeat (2) step();
        chk("rst_gnt", {bus.m0_gnt, bus.m1_gnt}, 2'b00);
        chk("rst_flags", {bus.m0_af_full, bus.m0_wdf_full, bus.m1_af_full, bus.m1_wdf_full}, 4'hF);
        chk("rst_mask", bus.wdf_mask_din, 16'hFFFF);
        rst_n = 1'b1;

        // Single m0 transaction, also second af write blocked
        bus.m0_req = 1;
        step();
        bus.m0_req = 0; bus.m0_af_wr_en = 1; bus.m0_wdf_wr_en = 1;
        #1;
        chk("s1_c1_gnt", bus.m0_gnt, 1'b1);
        chk("s1_c1_af", bus.af_wr_en, 1'b1);
        chk("s1_c1_wdf", bus.wdf_wr_en, 1'b1);
        chk("s1_c1_addr", bus.af_addr_din, 31'h1234_5678);
        chk("s1_c1_mask", bus.wdf_mask_din, 16'h00F0);
        step();
        #1;
        chk("s1_c2_gnt", bus.m0_gnt, 1'b1);
        chk("s1_c2_af_blocked", bus.af_wr_en, 1'b0);
        chk("s1_c2_wdf", bus.wdf_wr_en, 1'b1);
        chk("s1_c2_din", bus.wdf_din, 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF);
        step();
        #1;
        chk("s1_c3_gnt", bus.m0_gnt, 1'b0);
        chk("s1_c3_af", bus.af_wr_en, 1'b0);
        chk("s1_c3_mask", bus.wdf_mask_din, 16'hFFFF);
        chk("s1_c3_din", bus.wdf_din, 128'h0);
        clear_inputs();
        step();

        // Both masters requesting continuously
        do_reset();
        gq.delete();
        m1_flag_low = 1'b0;
        bus.m0_req = 1; bus.m0_af_wr_en = 1; bus.m0_wdf_wr_en = 1;
        bus.m1_req = 1; bus.m1_af_wr_en = 1; bus.m1_wdf_wr_en = 1;
        repeat (12) step();
`ifdef DDR2_WR_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1};
        chk("s2_m1_flags_seen_low", m1_flag_low, 1'b1);
`else
        exp_seq = '{0, 0, 0, 0};
        chk("s2_m1_flags_stay_high", m1_flag_low, 1'b0);
`endif
        chk("s2_grant_count", gq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (gq.size() > i) chk($sformatf("s2_grant_%0d", i), gq[i], exp_seq[i]);
            else chk($sformatf("s2_grant_%0d_missing", i), 1'b0, 1'b1);
        end
        clear_inputs();
        repeat (3) step();

        // m1 transaction with af then wdf back-pressure
        do_reset();
        bus.m1_req = 1; bus.m1_af_wr_en = 1; bus.m1_wdf_wr_en = 1;
        step();
        bus.m1_req = 0; bus.af_full = 1;
        #1;
        chk("s3_c1_gnt", bus.m1_gnt, 1'b1);
        chk("s3_c1_af", bus.af_wr_en, 1'b0);
        chk("s3_c1_wdf", bus.wdf_wr_en, 1'b1);
        chk("s3_c1_m1_af_full", bus.m1_af_full, 1'b1);
        step();
        bus.af_full = 0; bus.wdf_full = 1;
        #1;
        chk("s3_c2_af", bus.af_wr_en, 1'b1);
        chk("s3_c2_wdf", bus.wdf_wr_en, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("s3_stall%0d_gnt", i), bus.m1_gnt, 1'b1);
            chk($sformatf("s3_stall%0d_wdf", i), bus.wdf_wr_en, 1'b0);
            chk($sformatf("s3_stall%0d_af", i), bus.af_wr_en, 1'b0);
        end
        step();
        bus.wdf_full = 0;
        #1;
        chk("s3_release_wdf", bus.wdf_wr_en, 1'b1);
        chk("s3_release_gnt", bus.m1_gnt, 1'b1);
        step();
        #1;
        chk("s3_done_gnt", bus.m1_gnt, 1'b0);
        clear_inputs();
        step();

        // Reset mid-transaction, m0 wins afterwards
        do_reset();
        bus.m1_req = 1; bus.m1_af_wr_en = 1; bus.m1_wdf_wr_en = 1;
        step();
        bus.m1_req = 0;
        #1;
        chk("s4_c1_gnt", bus.m1_gnt, 1'b1);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("s4_rst_gnt", {bus.m0_gnt, bus.m1_gnt}, 2'b00);
        chk("s4_rst_en", {bus.af_wr_en, bus.wdf_wr_en}, 2'b00);
        chk("s4_rst_flags", {bus.m1_af_full, bus.m1_wdf_full}, 2'b11);
        bus.m0_req = 1; bus.m1_req = 1; bus.m0_af_wr_en = 1; bus.m0_wdf_wr_en = 1;
        step();
        rst_n = 1'b1;
        gq.delete();
        step();
        #1;
        chk("s4_post_m0_gnt", bus.m0_gnt, 1'b1);
        chk("s4_post_m1_gnt", bus.m1_gnt, 1'b0);
        clear_inputs();
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
